dff_pipe: RTL and testbench
===========================

// Module: dff_pipe
// PURPOSE
//  Parametrised elastic register pipeline: DEPTH stages of WIDTH-bit flops with per-stage valid bits.
//  Upstream and downstream use a valid/ready handshake. Bubbles collapse, flush clears all stages.
//  Successor to the single-bit D flip-flop; it is the generic retiming/delay stage placed between datapath blocks.
// PARAMETERS
//  WIDTH    8   data width in bits (>=1)
//  DEPTH    4   number of register stages (>=1)
//  RST_VAL  0   reset value of every data stage (WIDTH bits)
//  CNTW     $clog2(DEPTH+1)  localparam, width of o_cnt
// PORTS
//  i_clk    in   1      clock, all state updates on rising edge
//  i_rst    in   1      synchronous reset, active-high
//  i_valid  in   1      upstream data valid
//  i_data   in   WIDTH  upstream data
//  o_ready  out  1      pipeline can accept i_data this cycle
//  o_valid  out  1      stage DEPTH-1 holds valid data
//  o_data   out  WIDTH  data of stage DEPTH-1
//  i_ready  in   1      downstream accepts o_data this cycle
//  i_flush  in   1      synchronous clear of all valid bits
//  o_cnt    out  CNTW   number of valid stages (0..DEPTH)
// BEHAVIOUR
//  - Reset (i_rst=1 at an edge): all valid bits=0, all data stages=RST_VAL, o_cnt=0, so o_valid=0 and o_data=RST_VAL.
//    Reset overrides flush and handshake, and aborts in-flight data with no output.
//  - Stages are s[0] (input side) to s[DEPTH-1] (output side).
//    Ready chain (combinational): r[DEPTH]=i_ready; r[k]=!v[k] | r[k+1].
//  - o_ready = r[0] & !i_flush. It is combinational from i_ready; no skid buffer.
//  - Each edge, with no reset and no flush, for k=DEPTH-1..1: if r[k], then v[k]<=v[k-1] and, when v[k-1], d[k]<=d[k-1].
//  - Stage 0: if r[0], then v[0]<=i_valid, and d[0]<=i_data when i_valid.
//  - A stage that does not advance holds its data and valid bit.
//  - Data regs load only when the incoming valid is 1; bubbles never overwrite data.
//  - Transfer in: i_valid & o_ready at an edge. Transfer out: o_valid & i_ready at an edge.
//  - Latency with an empty pipe and i_ready=1: o_valid rises DEPTH edges after the accept edge.
//    The accept edge counts as edge 1, so DEPTH=1 gives valid right after the accept edge.
//  - Throughput: 1 word/cycle sustained when i_ready=1. Order is preserved; no loss, no duplication.
//  - Backpressure: with i_ready=0, words advance into empty stages (bubble collapse) until all DEPTH stages are valid.
//    o_ready then drops to 0 in that same cycle (combinational).
//  - Full + simultaneous: when the pipe is full and i_ready=1, o_ready=1. In- and out-transfers happen on the same edge.
//  - Flush: i_flush=1 at an edge clears all v[k] and sets o_cnt=0. Data regs are unchanged.
//    o_ready=0 during flush, so no word is accepted. An o_valid&i_ready transfer in the flush cycle still counts as delivered.
//  - o_cnt is a registered count, equal to the popcount of v after every edge.
//    o_cnt <= o_cnt + in - out, computed at width CNTW. It is 0 after reset/flush and never exceeds DEPTH.
//  - While o_valid=1 and i_ready=0: o_data is stable and o_valid stays 1 (AXI-style hold).
//  - No X on outputs after the first reset edge, regardless of i_data.
// TESTING (WIDTH=8, DEPTH=4, RST_VAL=8'hA5 unless noted)
//  1 Reset: i_rst=1 for 2 edges -> o_valid=0, o_data=8'hA5, o_cnt=0, o_ready=1 (with i_ready=1).
//  2 Stream: i_ready=1, push 0x01..0x10 back-to-back.
//    -> 0x01 on o_data with o_valid 4 edges after its accept, then 1 word/cycle in order, o_cnt=4 steady.
//  3 Backpressure: i_ready=0, push 0x11,0x22,0x33,0x44,0x55 -> first 4 accepted, o_ready=0, o_cnt=4, 0x55 held.
//    Then i_ready=1 -> outputs 11,22,33,44,55 in order.
//  4 Bubble: push 0xAA, idle 2 cycles, push 0xBB with i_ready=0 -> both collapse to s[3],s[2], o_cnt=2.
//    Release -> AA then BB on consecutive cycles.
//  5 Flush: 3 words in flight, assert i_flush 1 cycle with i_valid=1 -> o_cnt=0, o_valid=0 next cycle.
//    The flush-cycle word is not accepted, and none of the 3 flushed words ever appears.
//  6 Reset mid-stream + random: random i_valid/i_ready, 1000 cycles, i_rst pulses at random, DEPTH in {1,4,7}.
//    -> scoreboard exact order, o_cnt==popcount(v), o_data=8'hA5 after each reset.

Source files
------------

// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH stages of WIDTH-bit data with per-stage valid bits,
// valid/ready on both sides, bubble collapse under backpressure, and a synchronous flush.
module dff_pipe #(
   parameter int                 WIDTH   = 8,
   parameter int                 DEPTH   = 4,
   parameter logic [WIDTH-1:0]   RST_VAL = '0,
   localparam int                CNTW    = $clog2(DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   input  logic [WIDTH-1:0]  i_data,
   output logic              o_ready,
   output logic              o_valid,
   output logic [WIDTH-1:0]  o_data,
   input  logic              i_ready,
   input  logic              i_flush,
   output logic [CNTW-1:0]   o_cnt
);

   logic [DEPTH-1:0]  valid_q;
   logic [DEPTH-1:0]  valid_d;
   logic [WIDTH-1:0]  data_q [DEPTH];
   logic [WIDTH-1:0]  data_d [DEPTH];
   logic [CNTW-1:0]   cnt_q;
   logic [CNTW-1:0]   cnt_d;
   logic [DEPTH-1:0]  stage_rdy;
   logic              take_in;
   logic              take_out;

   // A stage may advance when it is empty or anything downstream of it can move.
   // Built as a running OR from the output side so no vector feeds back on itself.
   always_comb begin
      logic acc;
      acc = i_ready;
      stage_rdy = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         acc          = acc | ~valid_q[k];
         stage_rdy[k] = acc;
      end
   end

   assign o_ready  = stage_rdy[0] & ~i_flush;
   assign o_valid  = valid_q[DEPTH-1];
   assign o_data   = data_q[DEPTH-1];
   assign o_cnt    = cnt_q;

   assign take_in  = i_valid & o_ready;
   assign take_out = valid_q[DEPTH-1] & i_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (stage_rdy[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end
         end
      end
      if (stage_rdy[0]) begin
         valid_d[0] = i_valid;
         if (i_valid) begin
            data_d[0] = i_data;
         end
      end
      cnt_d = cnt_q + CNTW'(take_in) - CNTW'(take_out);
   end

   // Flush drops valid bits only; data registers keep their contents.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_q <= '0;
         cnt_q   <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            data_q[k] <= RST_VAL;
         end
      end else if (i_flush) begin
         valid_q <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: three instances (DEPTH 1, 4, 7) share one stimulus stream; each has
// its own word-order scoreboard, occupancy model and reset checks. Directed steps target DEPTH 4.
module tb_dff_pipe;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        i_ready;
   logic        i_flush;
   logic [7:0]  i_data;

   logic        ready_w [3];
   logic        valid_w [3];
   logic [7:0]  data_w  [3];
   logic [3:0]  cnt_w   [3];

   int          n_pass  = 0;
   int          n_total = 0;
   int          depths [3] = '{1, 4, 7};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int D  = (g == 0) ? 1 : ((g == 1) ? 4 : 7);
      localparam int CW = $clog2(D + 1);

      logic           ov;
      logic           ordy;
      logic [7:0]     od;
      logic [CW-1:0]  oc;

      dff_pipe #(.WIDTH(8), .DEPTH(D), .RST_VAL(8'hA5)) u_dut (
         .i_clk   (clk),
         .i_rst   (i_rst),
         .i_valid (i_valid),
         .i_data  (i_data),
         .o_ready (ordy),
         .o_valid (ov),
         .o_data  (od),
         .i_ready (i_ready),
         .i_flush (i_flush),
         .o_cnt   (oc)
      );

      assign ready_w[g] = ordy;
      assign valid_w[g] = ov;
      assign data_w[g]  = od;
      assign cnt_w[g]   = 4'(oc);

      // Every accepted word is appended here; words before index rd are delivered or discarded.
      logic [7:0] sb_q [$];
      int         rd       = 0;
      bit         armed    = 1'b0;
      bit         rst_last = 1'b0;

      // Stimulus side: record accepted words.
      always @(negedge clk) begin
         #1;
         if (!i_rst && i_valid && ordy) sb_q.push_back(i_data);
      end

      // Monitor side: occupancy, ready, ordered delivery, reset state.
      always @(negedge clk) begin
         int  occ;
         bit  exp_rdy;
         if (rst_last) begin
            chk($sformatf("d%0d_rst_valid", D), 32'(ov), 32'(0));
            chk($sformatf("d%0d_rst_data", D), 32'(od), 32'h0000_00A5);
            chk($sformatf("d%0d_rst_cnt", D), 32'(oc), 32'(0));
         end
         if (armed) begin
            occ     = sb_q.size() - rd;
            exp_rdy = ((occ < D) || i_ready) && !i_flush;
            chk($sformatf("d%0d_cnt", D), 32'(oc), 32'(occ));
            chk($sformatf("d%0d_ready", D), 32'(ordy), 32'(exp_rdy));
            if (ov && i_ready && !i_rst) begin
               if (rd < sb_q.size()) begin
                  chk($sformatf("d%0d_data", D), 32'(od), 32'(sb_q[rd]));
                  rd++;
               end else begin
                  chk($sformatf("d%0d_unexpected_out", D), 32'(ov), 32'(0));
               end
            end
         end
         if (i_rst) begin
            rd    = sb_q.size();
            armed = 1'b1;
         end else if (i_flush) begin
            rd = sb_q.size();
         end
         rst_last = i_rst;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers d until the DEPTH-4 instance accepts it, then drops i_valid.
   task automatic push_word(input logic [7:0] d);
      logic acc;
      acc     = 1'b0;
      i_valid = 1'b1;
      i_data  = d;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         acc = ready_w[1];
         step();
         if (acc) break;
      end
      if (!acc) chk("push_timeout", 32'(acc), 32'(1));
      i_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      i_valid = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      int lat [3];
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_flush = 1'b0;
      i_data  = 8'h00;

      // Reset state
      step();
      step();
      @(negedge clk);
      chk("reset_valid", 32'(valid_w[1]), 32'(0));
      chk("reset_data", 32'(data_w[1]), 32'h0000_00A5);
      chk("reset_cnt", 32'(cnt_w[1]), 32'(0));
      chk("reset_ready", 32'(ready_w[1]), 32'(1));
      step();
      i_rst = 1'b0;
      step();

      // Latency from an empty pipe: o_valid after DEPTH edges, accept edge counted as 1
      lat     = '{0, 0, 0};
      i_valid = 1'b1;
      i_data  = 8'h5A;
      step();
      i_valid = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         @(negedge clk);
         for (int g = 0; g < 3; g++) if (valid_w[g] && lat[g] == 0) lat[g] = e;
      end
      for (int g = 0; g < 3; g++) chk($sformatf("latency_d%0d", depths[g]), 32'(lat[g]), 32'(depths[g]));
      step();

      // Back-to-back stream
      for (int w = 1; w <= 16; w++) push_word(8'(w));
      idle(12);

      // Backpressure until full, fifth word held
      i_ready = 1'b0;
      push_word(8'h11);
      push_word(8'h22);
      push_word(8'h33);
      push_word(8'h44);
      i_valid = 1'b1;
      i_data  = 8'h55;
      repeat (3) step();
      @(negedge clk);
      chk("bp_ready", 32'(ready_w[1]), 32'(0));
      chk("bp_cnt", 32'(cnt_w[1]), 32'(4));
      chk("bp_valid", 32'(valid_w[1]), 32'(1));
      chk("bp_data", 32'(data_w[1]), 32'h0000_0011);
      step();
      i_ready = 1'b1;
      push_word(8'h55);
      idle(12);

      // Bubble collapse
      i_ready = 1'b0;
      push_word(8'hAA);
      idle(2);
      push_word(8'hBB);
      idle(4);
      @(negedge clk);
      chk("bubble_cnt", 32'(cnt_w[1]), 32'(2));
      chk("bubble_valid", 32'(valid_w[1]), 32'(1));
      chk("bubble_head", 32'(data_w[1]), 32'h0000_00AA);
      step();
      i_ready = 1'b1;
      @(negedge clk);
      chk("bubble_out1", 32'(data_w[1]), 32'h0000_00AA);
      step();
      @(negedge clk);
      chk("bubble_out2_valid", 32'(valid_w[1]), 32'(1));
      chk("bubble_out2", 32'(data_w[1]), 32'h0000_00BB);
      step();
      idle(12);

      // Flush with three words in flight and a word offered in the flush cycle
      push_word(8'hC1);
      push_word(8'hC2);
      push_word(8'hC3);
      i_valid = 1'b1;
      i_data  = 8'hEE;
      i_flush = 1'b1;
      step();
      i_flush = 1'b0;
      i_valid = 1'b0;
      @(negedge clk);
      chk("flush_cnt", 32'(cnt_w[1]), 32'(0));
      chk("flush_valid", 32'(valid_w[1]), 32'(0));
      step();
      idle(12);

      // Random traffic with flush and reset pulses
      for (int c = 0; c < 1000; c++) begin
         i_rst   = ($urandom_range(0, 59) == 0);
         i_flush = ($urandom_range(0, 39) == 0);
         i_valid = ($urandom_range(0, 3) != 0);
         i_ready = ($urandom_range(0, 2) != 0);
         i_data  = 8'($urandom);
         step();
      end
      i_rst   = 1'b0;
      i_flush = 1'b0;
      i_ready = 1'b1;
      idle(15);
      @(negedge clk);
      for (int g = 0; g < 3; g++) chk($sformatf("drain_cnt_d%0d", depths[g]), 32'(cnt_w[g]), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
